hqm_jg_clk_mon: RTL and testbench
=================================

HQM_JG_CLK_MON -- requirements
Module: hqm_jg_clk_mon

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the expected half-period value; must match the divider-mode clock generator it observes.
REQ-002 SHALL have parameter ECNTW, default 16: width of the saturating edge counter.
REQ-003 SHALL have port reference_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reference_rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port mon_en  input  1  monitor enable; low forces IDLE.
REQ-006 SHALL have port clk_in  input  1  generated divider-mode clock, sampled as data.
REQ-007 SHALL have port exp_freq  input  WIDTH  expected half-period in reference cycles; 0 means 2^WIDTH.
REQ-008 SHALL have port err_clr  input  1  clears err_sticky.
REQ-009 SHALL have port meas_valid  output  1  one-cycle pulse: a checked level has completed.
REQ-010 SHALL have port meas_width  output  WIDTH+1  width of the completed level.
REQ-011 SHALL have port meas_level  output  1  value of the completed level.
REQ-012 SHALL have port err_width  output  1  pulse: level ended early.
REQ-013 SHALL have port err_stuck  output  1  pulse: level exceeded expected width.
REQ-014 SHALL have port err_sticky  output  1  OR of all errors since the last clear.
REQ-015 SHALL have port edge_cnt  output  ECNTW  saturating count of edges seen in TRACK.
REQ-016 SHALL have port state  output  2  current FSM state.

Function
REQ-017 SHALL register clk_in into samp_f every cycle; edge = (clk_in != samp_f), evaluated combinationally against the registered sample.
REQ-018 SHALL capture exp_q = (exp_freq==0 ? 2^WIDTH : exp_freq) on the IDLE->ACQUIRE transition only; exp_freq changes are ignored until the next entry to ACQUIRE.
REQ-019 SHALL implement the states IDLE=0, ACQUIRE=1 and TRACK=2; encoding 3 is illegal and SHALL recover to IDLE.
REQ-020 SHALL go from IDLE to ACQUIRE when mon_en=1.
REQ-021 SHALL, in ACQUIRE, go to TRACK on the first edge with run_f<=1 and perform no check.
REQ-022 SHALL, in TRACK on an edge, register the following on the next cycle: meas_valid=1, meas_width=run_f, meas_level=samp_f, err_width=(run_f<exp_q); it SHALL then set run_f<=1 and increment edge_cnt, saturating at all-ones.
REQ-023 SHALL, in TRACK with no edge, increment run_f, saturating at 2^(WIDTH+1)-1.
REQ-024 SHALL, in TRACK with no edge and run_f==exp_q, pulse err_stuck on the next cycle and go to ACQUIRE.
REQ-025 SHALL make mon_en=0 force IDLE from any state on the next cycle, clear run_f and suppress pulses; edge_cnt and err_sticky SHALL be held.
REQ-026 SHALL set err_sticky whenever err_width or err_stuck is asserted; if an error and err_clr occur in the same cycle, err_sticky SHALL stay 1.
REQ-027 SHALL limit latency from clk_in change to meas_valid or err_* to exactly 1 cycle.

Reset
REQ-028 SHALL, with reference_rst_n=0 at a clock edge, set state=IDLE, samp_f=0, run_f=0, exp_q=0, edge_cnt=0, err_sticky=0 and all pulses=0, including when reset arrives mid-TRACK.
REQ-029 SHALL, on the first cycle after reset release, evaluate edge against samp_f=0; such an edge SHALL not be checked because the block is in IDLE or ACQUIRE.

Structure
REQ-030 SHALL define the state enum typedef hqm_jg_clk_mon_state_t and the encodings of REQ-019 in hqm_AW_pkg.
REQ-031 SHALL place the edge detector and run counter in one sub-module, hqm_jg_clk_mon_run (ports: sample, edge, run, saturation).
REQ-032 SHALL not depend on or instantiate the clock generator.

Verification (WIDTH=4)
REQ-033 SHALL cover: exp_freq=3 with clk_in toggling every 3 cycles -> meas_valid every 3 cycles, meas_width=3, no errors, edge_cnt increments.
REQ-034 SHALL cover: exp_freq=0 with a toggle every 16 cycles -> meas_width=16, no errors.
REQ-035 SHALL cover: exp_freq=3 in TRACK with a toggle after 2 cycles -> err_width=1, meas_width=2, err_sticky=1.
REQ-036 SHALL cover: exp_freq=3 in TRACK with clk_in held -> err_stuck pulses once when run_f=3, state goes to ACQUIRE, and the next edge returns the block to TRACK without a check.
REQ-037 SHALL cover: err_clr asserted in the same cycle as err_width -> err_sticky remains 1; err_clr alone on the next cycle -> err_sticky=0.
REQ-038 SHALL cover: reference_rst_n=0 for 1 cycle mid-TRACK with edge_cnt=5 -> state=IDLE, edge_cnt=0, all outputs 0.

Source files
------------

// File: rtl/hqm_AW_pkg.sv
// Shared types for the divider-mode clock monitor.
//   hqm_jg_clk_mon_state_t : monitor FSM state (IDLE, ACQUIRE, TRACK; 3 is illegal)
package hqm_AW_pkg;

  typedef enum logic [1:0] {
    HQM_JG_CLK_MON_IDLE    = 2'd0,
    HQM_JG_CLK_MON_ACQUIRE = 2'd1,
    HQM_JG_CLK_MON_TRACK   = 2'd2
  } hqm_jg_clk_mon_state_t;

endpackage

// File: rtl/hqm_jg_clk_mon_run.sv
// Edge detector and run-length counter for the clock monitor.
//   clk, rst_n  : reference clock, synchronous active-low reset
//   clk_in      : observed clock, sampled as data
//   clr         : clear the run counter (takes priority)
//   count_en    : allow the run counter to advance on non-edge cycles
//   sample      : registered copy of clk_in
//   edge_seen   : clk_in differs from the registered sample this cycle
//   run         : cycles spent at the current level (loads 1 on an edge)
//   saturation  : run counter is at all-ones
module hqm_jg_clk_mon_run #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_in,
  input  logic           clr,
  input  logic           count_en,
  output logic           sample,
  output logic           edge_seen,
  output logic [WIDTH:0] run,
  output logic           saturation
);

  localparam int RW = WIDTH + 1;

  assign edge_seen  = (clk_in != sample);
  assign saturation = &run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample <= 1'b0;
      run    <= '0;
    end else begin
      sample <= clk_in;
      if (clr) begin
        run <= '0;
      end else if (edge_seen) begin
        run <= RW'(1);
      end else if (count_en && !saturation) begin
        run <= run + RW'(1);
      end
    end
  end

endmodule

// File: rtl/hqm_jg_clk_mon.sv
// Divider-mode clock monitor: measures the width of each level of clk_in in
// reference_clk cycles and flags levels that end early or last too long.
//   reference_clk, reference_rst_n : clock, synchronous active-low reset
//   mon_en     : enable; low forces IDLE
//   clk_in     : observed clock (sampled as data)
//   exp_freq   : expected half-period in reference cycles, 0 means 2^WIDTH
//   err_clr    : clear err_sticky
//   meas_valid/meas_width/meas_level : completed-level report (1-cycle pulse)
//   err_width  : level ended before the expected width
//   err_stuck  : level reached the expected width with no edge
//   err_sticky : accumulated errors since the last clear
//   edge_cnt   : saturating count of edges checked in TRACK
//   state      : current FSM state
module hqm_jg_clk_mon
  import hqm_AW_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ECNTW = 16
) (
  input  logic             reference_clk,
  input  logic             reference_rst_n,
  input  logic             mon_en,
  input  logic             clk_in,
  input  logic [WIDTH-1:0] exp_freq,
  input  logic             err_clr,
  output logic             meas_valid,
  output logic [WIDTH:0]   meas_width,
  output logic             meas_level,
  output logic             err_width,
  output logic             err_stuck,
  output logic             err_sticky,
  output logic [ECNTW-1:0] edge_cnt,
  output logic [1:0]       state
);

  hqm_jg_clk_mon_state_t state_q, state_d;

  logic           sample;
  logic           edge_seen;
  logic [WIDTH:0] run;
  logic           saturation;
  logic [WIDTH:0] exp_q;
  logic [WIDTH:0] exp_sel;

  logic           valid_d;
  logic [WIDTH:0] width_d;
  logic           level_d;
  logic           err_width_d;
  logic           err_stuck_d;
  logic           cnt_inc;
  logic           capture;

  hqm_jg_clk_mon_run #(.WIDTH(WIDTH)) u_run (
    .clk        (reference_clk),
    .rst_n      (reference_rst_n),
    .clk_in     (clk_in),
    .clr        (!mon_en || (state_q == HQM_JG_CLK_MON_IDLE)),
    .count_en   (state_q == HQM_JG_CLK_MON_TRACK),
    .sample     (sample),
    .edge_seen  (edge_seen),
    .run        (run),
    .saturation (saturation)
  );

  assign exp_sel = (exp_freq == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, exp_freq};
  assign state   = state_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = 1'b0;
    width_d     = meas_width;
    level_d     = meas_level;
    err_width_d = 1'b0;
    err_stuck_d = 1'b0;
    cnt_inc     = 1'b0;
    capture     = 1'b0;

    case (state_q)
      HQM_JG_CLK_MON_IDLE: begin
        if (mon_en) begin
          state_d = HQM_JG_CLK_MON_ACQUIRE;
          capture = 1'b1;
        end
      end
      HQM_JG_CLK_MON_ACQUIRE: begin
        if (edge_seen) state_d = HQM_JG_CLK_MON_TRACK;
      end
      HQM_JG_CLK_MON_TRACK: begin
        if (edge_seen) begin
          valid_d     = 1'b1;
          width_d     = run;
          level_d     = sample;
          err_width_d = (run < exp_q);
          cnt_inc     = 1'b1;
        end else if ((run == exp_q) || saturation) begin
          // Saturation can only be reached past exp_q; kept as a backstop.
          err_stuck_d = 1'b1;
          state_d     = HQM_JG_CLK_MON_ACQUIRE;
        end
      end
      default: state_d = HQM_JG_CLK_MON_IDLE;
    endcase

    if (!mon_en) begin
      state_d     = HQM_JG_CLK_MON_IDLE;
      valid_d     = 1'b0;
      width_d     = meas_width;
      level_d     = meas_level;
      err_width_d = 1'b0;
      err_stuck_d = 1'b0;
      cnt_inc     = 1'b0;
      capture     = 1'b0;
    end
  end

  always_ff @(posedge reference_clk) begin
    if (!reference_rst_n) begin
      state_q    <= HQM_JG_CLK_MON_IDLE;
      exp_q      <= '0;
      meas_valid <= 1'b0;
      meas_width <= '0;
      meas_level <= 1'b0;
      err_width  <= 1'b0;
      err_stuck  <= 1'b0;
      err_sticky <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      meas_valid <= valid_d;
      meas_width <= width_d;
      meas_level <= level_d;
      err_width  <= err_width_d;
      err_stuck  <= err_stuck_d;
      if (capture) exp_q <= exp_sel;
      if (cnt_inc && !(&edge_cnt)) edge_cnt <= edge_cnt + ECNTW'(1);
      // Sticky rises with the pulse and is also held by the visible pulse,
      // so a clear coinciding with a reported error does not drop it.
      err_sticky <= (err_sticky && !err_clr) || err_width || err_stuck
                    || err_width_d || err_stuck_d;
    end
  end

endmodule

// File: tb/tb_hqm_jg_clk_mon.sv
// Directed self-checking bench for hqm_jg_clk_mon (WIDTH=4).
module tb_hqm_jg_clk_mon;

  localparam int WIDTH = 4;
  localparam int ECNTW = 16;

  logic             reference_clk = 1'b0;
  logic             reference_rst_n;
  logic             mon_en;
  logic             clk_in;
  logic [WIDTH-1:0] exp_freq;
  logic             err_clr;
  logic             meas_valid;
  logic [WIDTH:0]   meas_width;
  logic             meas_level;
  logic             err_width;
  logic             err_stuck;
  logic             err_sticky;
  logic [ECNTW-1:0] edge_cnt;
  logic [1:0]       state;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  logic        lvl;

  hqm_jg_clk_mon #(.WIDTH(WIDTH), .ECNTW(ECNTW)) dut (
    .reference_clk   (reference_clk),
    .reference_rst_n (reference_rst_n),
    .mon_en          (mon_en),
    .clk_in          (clk_in),
    .exp_freq        (exp_freq),
    .err_clr         (err_clr),
    .meas_valid      (meas_valid),
    .meas_width      (meas_width),
    .meas_level      (meas_level),
    .err_width       (err_width),
    .err_stuck       (err_stuck),
    .err_sticky      (err_sticky),
    .edge_cnt        (edge_cnt),
    .state           (state)
  );

  always #5 reference_clk = ~reference_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge reference_clk);
    #1;
  endtask

  task automatic toggle_tick();
    clk_in = ~clk_in;
    tick();
  endtask

  initial begin
    reference_rst_n = 1'b0;
    mon_en          = 1'b0;
    clk_in          = 1'b0;
    exp_freq        = 4'd3;
    err_clr         = 1'b0;
    tick();
    tick();
    check("rst_state",  32'(state),      32'd0);
    check("rst_ecnt",   32'(edge_cnt),   32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_valid",  32'(meas_valid), 32'd0);
    check("rst_width",  32'(meas_width), 32'd0);

    reference_rst_n = 1'b1;
    mon_en          = 1'b1;
    tick();
    check("acq_entry", 32'(state), 32'd1);

    toggle_tick();
    check("trk_entry",       32'(state),      32'd2);
    check("trk_entry_valid", 32'(meas_valid), 32'd0);
    check("trk_entry_ecnt",  32'(edge_cnt),   32'd0);

    // Nominal: toggle every 3 cycles against exp_freq=3
    for (int k = 0; k < 4; k++) begin
      tick();
      check("nom_gap_valid", 32'(meas_valid), 32'd0);
      tick();
      lvl = clk_in;
      toggle_tick();
      check("nom_valid", 32'(meas_valid), 32'd1);
      check("nom_width", 32'(meas_width), 32'd3);
      check("nom_level", 32'(meas_level), 32'(lvl));
      check("nom_errw",  32'(err_width),  32'd0);
      check("nom_errs",  32'(err_stuck),  32'd0);
      check("nom_ecnt",  32'(edge_cnt),   32'(k + 1));
    end
    check("nom_sticky", 32'(err_sticky), 32'd0);

    // Level ends after 2 cycles
    tick();
    lvl = clk_in;
    toggle_tick();
    check("ew_valid",  32'(meas_valid), 32'd1);
    check("ew_width",  32'(meas_width), 32'd2);
    check("ew_level",  32'(meas_level), 32'(lvl));
    check("ew_errw",   32'(err_width),  32'd1);
    check("ew_sticky", 32'(err_sticky), 32'd1);
    check("ew_ecnt",   32'(edge_cnt),   32'd5);

    // Clear while err_width is visible, then clear alone
    err_clr = 1'b1;
    tick();
    check("clr_with_err_sticky", 32'(err_sticky), 32'd1);
    check("clr_with_err_errw",   32'(err_width),  32'd0);
    tick();
    check("clr_alone_sticky", 32'(err_sticky), 32'd0);
    err_clr = 1'b0;

    // Held clk_in: run reaches 3 with no edge
    tick();
    check("stuck_pulse",  32'(err_stuck),  32'd1);
    check("stuck_state",  32'(state),      32'd1);
    check("stuck_valid",  32'(meas_valid), 32'd0);
    check("stuck_sticky", 32'(err_sticky), 32'd1);
    tick();
    check("stuck_once",   32'(err_stuck),  32'd0);
    check("stuck_hold_state", 32'(state),  32'd1);
    toggle_tick();
    check("reacq_state", 32'(state),      32'd2);
    check("reacq_valid", 32'(meas_valid), 32'd0);
    check("reacq_errw",  32'(err_width),  32'd0);
    check("reacq_ecnt",  32'(edge_cnt),   32'd5);

    // One-cycle reset mid-TRACK
    reference_rst_n = 1'b0;
    tick();
    check("mid_rst_state",  32'(state),      32'd0);
    check("mid_rst_ecnt",   32'(edge_cnt),   32'd0);
    check("mid_rst_sticky", 32'(err_sticky), 32'd0);
    check("mid_rst_valid",  32'(meas_valid), 32'd0);
    check("mid_rst_width",  32'(meas_width), 32'd0);
    check("mid_rst_level",  32'(meas_level), 32'd0);
    check("mid_rst_errw",   32'(err_width),  32'd0);
    check("mid_rst_errs",   32'(err_stuck),  32'd0);

    // Release with clk_in=1 against samp_f=0: edge seen in IDLE, unchecked
    clk_in          = 1'b1;
    exp_freq        = 4'd0;
    reference_rst_n = 1'b1;
    tick();
    check("rel_state", 32'(state),      32'd1);
    check("rel_valid", 32'(meas_valid), 32'd0);
    exp_freq = 4'd3;  // must not affect the captured 16
    toggle_tick();
    check("w16_trk", 32'(state), 32'd2);
    for (int k = 0; k < 2; k++) begin
      repeat (15) tick();
      lvl = clk_in;
      toggle_tick();
      check("w16_valid", 32'(meas_valid), 32'd1);
      check("w16_width", 32'(meas_width), 32'd16);
      check("w16_level", 32'(meas_level), 32'(lvl));
      check("w16_errw",  32'(err_width),  32'd0);
      check("w16_errs",  32'(err_stuck),  32'd0);
      check("w16_ecnt",  32'(edge_cnt),   32'(k + 1));
    end
    check("w16_sticky", 32'(err_sticky), 32'd0);

    // Disable with a coincident edge: pulse suppressed, counters held
    mon_en = 1'b0;
    toggle_tick();
    check("dis_state",  32'(state),      32'd0);
    check("dis_valid",  32'(meas_valid), 32'd0);
    check("dis_ecnt",   32'(edge_cnt),   32'd2);
    check("dis_sticky", 32'(err_sticky), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
